// File: rtl/minibus_pkg.sv
// Shared types for the minibus address decoder: response status codes and
// the decoder's transaction-state encoding.
package minibus_pkg;

   typedef enum logic [1:0] {
      MB_OK      = 2'd0,
      MB_DECERR  = 2'd1,
      MB_TIMEOUT = 2'd2
   } minibus_res_code_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } minibus_dec_state_t;

endpackage

// File: rtl/minibus_addr_match.sv
// Combinational address-map lookup: flags every slave whose [start, end) region
// holds the address, then keeps only the lowest-index hit.
module minibus_addr_match
   import minibus_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 32
) (
   input  logic [ADDR_W-1:0]            addr,
   input  logic [NUM_SLAVES*ADDR_W-1:0] map_start,
   input  logic [NUM_SLAVES*ADDR_W-1:0] map_end,
   output logic [NUM_SLAVES-1:0]        hit,
   output logic                         any_hit
);

   logic [NUM_SLAVES-1:0] w_raw_hit;
   logic                  w_found;

   // Raw region compare; a region with start >= end can never satisfy both bounds
   always_comb begin
      w_raw_hit = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_raw_hit[i] = (map_start[i*ADDR_W +: ADDR_W] <= addr) &&
                        (addr < map_end[i*ADDR_W +: ADDR_W]);
      end
   end

   // Priority resolution toward the lowest index
   always_comb begin
      hit     = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (w_raw_hit[i] && !w_found) begin
            hit[i]  = 1'b1;
            w_found = 1'b1;
         end else begin
            hit[i]  = 1'b0;
         end
      end
   end

   assign any_hit = |w_raw_hit;

endmodule

// File: rtl/minibus_decoder_seq.sv
// Registered minibus decoder: one master, NUM_SLAVES slaves, runtime address map,
// with DECERR/TIMEOUT error responses and a saturating error counter.
module minibus_decoder_seq
   import minibus_pkg::*;
#(
   parameter int NUM_SLAVES     = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ERRCNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SLAVES*ADDR_W-1:0] map_start,
   input  logic [NUM_SLAVES*ADDR_W-1:0] map_end,
   input  logic                         m_req_valid,
   output logic                         m_req_ready,
   input  logic [ADDR_W-1:0]            m_req_addr,
   input  logic                         m_req_wen,
   input  logic [DATA_W-1:0]            m_req_wdata,
   output logic                         m_res_valid,
   output logic [DATA_W-1:0]            m_res_rdata,
   output logic [1:0]                   m_res_code,
   output logic [NUM_SLAVES-1:0]        s_sel,
   output logic [ADDR_W-1:0]            s_req_addr,
   output logic                         s_req_wen,
   output logic [DATA_W-1:0]            s_req_wdata,
   input  logic [NUM_SLAVES-1:0]        s_res_ready,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_res_rdata,
   output logic [ERRCNT_W-1:0]          err_count
);

   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   minibus_dec_state_t r_state;
   minibus_dec_state_t w_state_nxt;
   minibus_res_code_t  r_res_code;

   logic [NUM_SLAVES-1:0] r_sel;
   logic [ADDR_W-1:0]     r_req_addr;
   logic                  r_req_wen;
   logic [DATA_W-1:0]     r_req_wdata;
   logic [TO_W-1:0]       r_cnt;
   logic                  r_res_valid;
   logic [DATA_W-1:0]     r_res_rdata;
   logic [ERRCNT_W-1:0]   r_err_count;

   logic [NUM_SLAVES-1:0] w_hit;
   logic                  w_any_hit;
   logic                  w_sel_ready;
   logic                  w_expire;
   logic [DATA_W-1:0]     w_sel_rdata;
   logic [ERRCNT_W-1:0]   w_err_inc;

   minibus_addr_match #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W)
   ) u_match (
      .addr      (m_req_addr),
      .map_start (map_start),
      .map_end   (map_end),
      .hit       (w_hit),
      .any_hit   (w_any_hit)
   );

   assign w_sel_ready = |(s_res_ready & r_sel);
   assign w_expire    = TO_EN && (r_cnt == TO_LAST);
   assign w_err_inc   = (r_err_count == '1) ? r_err_count : r_err_count + ERRCNT_W'(1);

   // Read data of the latched slave; r_sel is one-hot or zero, so an OR-mux suffices
   always_comb begin
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_sel[i]) begin
            w_sel_rdata = w_sel_rdata | s_res_rdata[i*DATA_W +: DATA_W];
         end else begin
            w_sel_rdata = w_sel_rdata;
         end
      end
   end

   // Transaction state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a slave's ready beats a timeout expiring in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (m_req_valid) begin
               w_state_nxt = w_any_hit ? ACCESS : RESP;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACCESS: begin
            if (w_sel_ready || w_expire) begin
               w_state_nxt = RESP;
            end else begin
               w_state_nxt = ACCESS;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request capture, slave select, timeout counter and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel       <= '0;
         r_req_addr  <= '0;
         r_req_wen   <= 1'b0;
         r_req_wdata <= '0;
         r_cnt       <= '0;
         r_res_valid <= 1'b0;
         r_res_rdata <= '0;
         r_res_code  <= MB_OK;
         r_err_count <= '0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (m_req_valid) begin
                  r_req_addr  <= m_req_addr;
                  r_req_wen   <= m_req_wen;
                  r_req_wdata <= m_req_wdata;
                  r_cnt       <= '0;
                  if (w_any_hit) begin
                     r_sel <= w_hit;
                  end else begin
                     r_sel       <= '0;
                     r_res_valid <= 1'b1;
                     r_res_code  <= MB_DECERR;
                     r_res_rdata <= '0;
                     r_err_count <= w_err_inc;
                  end
               end
            end
            ACCESS: begin
               if (w_sel_ready) begin
                  r_sel       <= '0;
                  r_res_valid <= 1'b1;
                  r_res_code  <= MB_OK;
                  r_res_rdata <= w_sel_rdata;
               end else if (w_expire) begin
                  r_sel       <= '0;
                  r_res_valid <= 1'b1;
                  r_res_code  <= MB_TIMEOUT;
                  r_res_rdata <= '0;
                  r_err_count <= w_err_inc;
               end else if (TO_EN) begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            default: begin
               r_sel <= '0;
            end
         endcase
      end
   end

   assign m_req_ready = (r_state == IDLE);
   assign m_res_valid = r_res_valid;
   assign m_res_rdata = r_res_rdata;
   assign m_res_code  = r_res_code;
   assign s_sel       = r_sel;
   assign s_req_addr  = r_req_addr;
   assign s_req_wen   = r_req_wen;
   assign s_req_wdata = r_req_wdata;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_minibus_decoder_seq.sv
// Scoreboard bench for minibus_decoder_seq: directed map/timeout/reset cases plus
// randomized traffic, checked against a region-table reference model.
module tb_minibus_decoder_seq;

   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam int EW = 3;

   typedef struct {
      logic [1:0]    code;
      logic [DW-1:0] rdata;
      int            cyc;
      logic [EW-1:0] err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NS*AW-1:0] map_start;
   logic [NS*AW-1:0] map_end;
   logic             m_req_valid;
   logic             m_req_ready;
   logic [AW-1:0]    m_req_addr;
   logic             m_req_wen;
   logic [DW-1:0]    m_req_wdata;
   logic             m_res_valid;
   logic [DW-1:0]    m_res_rdata;
   logic [1:0]       m_res_code;
   logic [NS-1:0]    s_sel;
   logic [AW-1:0]    s_req_addr;
   logic             s_req_wen;
   logic [DW-1:0]    s_req_wdata;
   logic [NS-1:0]    s_res_ready;
   logic [NS*DW-1:0] s_res_rdata;
   logic [EW-1:0]    err_count;

   logic [AW-1:0] ms [NS];
   logic [AW-1:0] me [NS];
   exp_t          sb [$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   logic [EW-1:0] exp_err = '0;

   for (genvar g = 0; g < NS; g++) begin : g_map
      assign map_start[g*AW +: AW] = ms[g];
      assign map_end[g*AW +: AW]   = me[g];
   end

   minibus_decoder_seq #(
      .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)
   ) dut (
      .clk(clk), .rst(rst), .map_start(map_start), .map_end(map_end),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
      .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_res_valid(m_res_valid),
      .m_res_rdata(m_res_rdata), .m_res_code(m_res_code), .s_sel(s_sel),
      .s_req_addr(s_req_addr), .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata),
      .s_res_ready(s_res_ready), .s_res_rdata(s_res_rdata), .err_count(err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference decode: scan from the top so the lowest matching index is the last written
   function automatic int decode(input logic [AW-1:0] a);
      int r = -1;
      for (int i = NS - 1; i >= 0; i--) begin
         if (ms[i] <= a && a < me[i]) r = i;
      end
      return r;
   endfunction

   task automatic set_region(input int i, input logic [AW-1:0] s, input logic [AW-1:0] e);
      ms[i] = s;
      me[i] = e;
   endtask

   task automatic randomize_map();
      for (int i = 0; i < NS; i++) begin
         ms[i] = AW'($urandom_range(0, 32'h0000_FFFF));
         me[i] = ($urandom_range(0, 3) == 0) ? ms[i] : ms[i] + AW'($urandom_range(1, 32'h0000_6000));
      end
   endtask

   task automatic drive_slaves(input int idx, input bit rdy, input logic [DW-1:0] rd);
      s_res_ready = NS'($urandom);
      for (int i = 0; i < NS; i++) s_res_rdata[i*DW +: DW] = $urandom;
      if (idx >= 0) begin
         s_res_ready[idx]         = rdy;
         s_res_rdata[idx*DW +: DW] = rd;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("idle_wait_expired", 64'(n), 64'(0));
   endtask

   // One request; the addressed slave answers k cycles after accept (k > TO means never)
   task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                      input int k, input logic [DW-1:0] rd, input bit scramble);
      int idx, rel, c0, sel_last;
      exp_t e;
      logic [NS-1:0] esel;
      wait_idle();
      idx = decode(a);
      c0  = cyc;
      if (idx < 0) begin
         e.code = 2'd1; e.rdata = '0; rel = 1;
      end else if (k <= TO) begin
         e.code = 2'd0; e.rdata = rd; rel = k + 1;
      end else begin
         e.code = 2'd2; e.rdata = '0; rel = TO + 1;
      end
      if (e.code != 2'd0 && exp_err != '1) exp_err = exp_err + EW'(1);
      e.cyc = c0 + rel;
      e.err = exp_err;
      sb.push_back(e);
      sel_last = (idx < 0) ? 0 : ((k < TO) ? k : TO);
      m_req_valid = 1'b1; m_req_addr = a; m_req_wen = w; m_req_wdata = wd;
      drive_slaves(idx, 1'b0, rd);
      for (int j = 1; j <= TO + 2; j++) begin
         @(negedge clk);
         m_req_valid = 1'b0;
         m_req_addr  = $urandom;
         m_req_wen   = ~w;
         m_req_wdata = $urandom;
         if (scramble && j == 1) randomize_map();
         drive_slaves(idx, (j == k), rd);
         esel = '0;
         if (idx >= 0 && j <= sel_last) esel[idx] = 1'b1;
         chk("s_sel", 64'(s_sel), 64'(esel));
         if (j == 1 || j <= sel_last) begin
            chk("s_req_addr", 64'(s_req_addr), 64'(a));
            chk("s_req_wen", 64'(s_req_wen), 64'(w));
            chk("s_req_wdata", 64'(s_req_wdata), 64'(wd));
         end
         if (j == rel + 1) begin
            chk("hold_code", 64'(m_res_code), 64'(e.code));
            chk("hold_rdata", 64'(m_res_rdata), 64'(e.rdata));
         end
      end
   endtask

   // Response monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (m_res_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_response", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("res_cycle", 64'(cyc), 64'(e.cyc));
            chk("res_code", 64'(m_res_code), 64'(e.code));
            chk("res_rdata", 64'(m_res_rdata), 64'(e.rdata));
            chk("err_count", 64'(err_count), 64'(e.err));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; m_req_valid = 1'b0; m_req_addr = '0; m_req_wen = 1'b0; m_req_wdata = '0;
      s_res_ready = '0; s_res_rdata = '0;
      for (int i = 0; i < NS; i++) set_region(i, '0, '0);
      repeat (3) @(negedge clk);
      chk("rst_res_valid", 64'(m_res_valid), 64'(0));
      chk("rst_s_sel", 64'(s_sel), 64'(0));
      chk("rst_res_code", 64'(m_res_code), 64'(0));
      chk("rst_res_rdata", 64'(m_res_rdata), 64'(0));
      chk("rst_s_req_addr", 64'(s_req_addr), 64'(0));
      chk("rst_s_req_wdata", 64'(s_req_wdata), 64'(0));
      chk("rst_s_req_wen", 64'(s_req_wen), 64'(0));
      chk("rst_err_count", 64'(err_count), 64'(0));
      chk("rst_ready", 64'(m_req_ready), 64'(1));
      rst = 1'b0;

      set_region(0, 32'h0000_0000, 32'h0000_1000);
      set_region(1, 32'h0000_1000, 32'h0000_2000);
      txn(32'h0000_1004, 1'b0, 32'h0, 2, 32'hCAFE_BABE, 1'b0);
      txn(32'h0000_0010, 1'b1, 32'h0000_0055, 1, 32'h1234_5678, 1'b0);
      txn(32'h0000_9000, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
      set_region(2, 32'h0000_0000, 32'h0000_2000);
      txn(32'h0000_0800, 1'b0, 32'h0, 3, 32'h0BAD_F00D, 1'b0);
      set_region(3, 32'h0000_3000, 32'h0000_3000);
      txn(32'h0000_3000, 1'b0, 32'h0, 1, 32'h1111_1111, 1'b0);
      txn(32'h0000_1800, 1'b0, 32'h0, 100, 32'h2222_2222, 1'b0);
      txn(32'h0000_1800, 1'b1, 32'hA5A5_A5A5, TO, 32'h3333_3333, 1'b0);
      txn(32'h0000_0004, 1'b0, 32'h0, TO + 1, 32'h4444_4444, 1'b0);

      // Reset during ACCESS: transaction vanishes, no response, counter cleared
      wait_idle();
      m_req_valid = 1'b1; m_req_addr = 32'h0000_0010; m_req_wen = 1'b0; s_res_ready = '0;
      @(negedge clk);
      m_req_valid = 1'b0;
      chk("pre_rst_s_sel", 64'(s_sel), 64'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_err = '0;
      chk("mid_rst_s_sel", 64'(s_sel), 64'(0));
      chk("mid_rst_ready", 64'(m_req_ready), 64'(1));
      chk("mid_rst_err", 64'(err_count), 64'(0));
      chk("mid_rst_code", 64'(m_res_code), 64'(0));
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_resp", 64'(m_res_valid), 64'(0));
      end

      for (int n = 0; n < (1 << EW) + 2; n++) begin
         txn(32'h0000_9000 + AW'(n), 1'b0, 32'h0, 1, 32'h0, 1'b0);
      end
      chk("err_saturated", 64'(err_count), 64'((1 << EW) - 1));

      for (int n = 0; n < 200; n++) begin
         logic [AW-1:0] a;
         randomize_map();
         a = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 32'h0000_FFFF));
         txn(a, 1'($urandom), $urandom, $urandom_range(1, TO + 2), $urandom, 1'b1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
